// File: rtl/crtc_init_sequencer.sv
// Programs the CRTC register file from a built-in mode table through the
// index/data register pair, arbitrating for the system bus between writes.
module crtc_init_sequencer #(
   parameter int STROBE_CYCLES = 2,
   parameter int NUM_REGS      = 16,
   parameter bit AUTO_START    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mode,
   output logic       bus_req,
   input  logic       bus_grant,
   output logic       crtc_select,
   output logic       crtc_rs,
   output logic [7:0] crtc_data,
   output logic       write_strobe,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   // Bus handshake: bus_req is held from acceptance until RELEASE. bus_grant
   // is only looked at in REQ and GAP, so a write already on the bus always
   // finishes; grant without an outstanding request is ignored.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      SETUP   = 3'd2,
      STROBE  = 3'd3,
      HOLD    = 3'd4,
      GAP     = 3'd5,
      RELEASE = 3'd6
   } state_t;

   localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES);
   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   state_t     state;
   logic       auto_pend;
   logic       mode_q;
   logic [4:0] reg_idx;
   logic       phase;
   logic [3:0] strb_cnt;
   logic       last_write;
   logic [4:0] next_idx;

   function automatic logic [7:0] table_byte(input logic m, input logic [4:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         5'd0:    b = 8'h31;
         5'd1:    b = 8'h28;
         5'd2:    b = 8'h29;
         5'd3:    b = 8'h0F;
         5'd4:    b = m ? 8'h20 : 8'h28;
         5'd5:    b = m ? 8'h03 : 8'h05;
         5'd6:    b = 8'h19;
         5'd7:    b = m ? 8'h1D : 8'h21;
         5'd9:    b = m ? 8'h09 : 8'h07;
         5'd12:   b = 8'h10;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // phase 0 = index write, phase 1 = data write of the same register
   function automatic logic [7:0] write_byte(input logic ph, input logic [4:0] idx,
                                             input logic m);
      return ph ? table_byte(m, idx) : {3'b000, idx};
   endfunction

   always_comb begin
      last_write = phase && (reg_idx == LAST_IDX);
      next_idx   = phase ? reg_idx + 5'd1 : reg_idx;
   end

   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         auto_pend    <= AUTO_START;
         mode_q       <= 1'b0;
         reg_idx      <= 5'd0;
         phase        <= 1'b0;
         strb_cnt     <= 4'd0;
         bus_req      <= 1'b0;
         crtc_select  <= 1'b0;
         crtc_rs      <= 1'b0;
         crtc_data    <= 8'h00;
         write_strobe <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         auto_pend <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start || auto_pend) begin
                  state   <= REQ;
                  mode_q  <= mode;
                  reg_idx <= 5'd0;
                  phase   <= 1'b0;
                  bus_req <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            REQ: begin
               if (bus_grant) begin
                  state       <= SETUP;
                  crtc_select <= 1'b1;
                  crtc_rs     <= phase;
                  crtc_data   <= write_byte(phase, reg_idx, mode_q);
               end
            end
            SETUP: begin
               state        <= STROBE;
               write_strobe <= 1'b1;
               strb_cnt     <= 4'd1;
            end
            STROBE: begin
               if (strb_cnt == STB_LAST) begin
                  state        <= HOLD;
                  write_strobe <= 1'b0;
               end else begin
                  strb_cnt <= strb_cnt + 4'd1;
               end
            end
            HOLD: begin
               state       <= GAP;
               crtc_select <= 1'b0;
            end
            GAP: begin
               if (last_write) begin
                  state   <= RELEASE;
                  bus_req <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  phase   <= !phase;
                  reg_idx <= next_idx;
                  if (bus_grant) begin
                     state       <= SETUP;
                     crtc_select <= 1'b1;
                     crtc_rs     <= !phase;
                     crtc_data   <= write_byte(!phase, next_idx, mode_q);
                  end else begin
                     state <= REQ;
                  end
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
